// File: rtl/mux_pkg.sv
// mux_pkg -- shared constants and helpers for the data_multiplexer block.
//
// Contents:
//   DEFAULT_WIDTH      default bits per data word
//   DEFAULT_SEL_WIDTH  default select bus width
//   DEFAULT_NUM_INPUTS default number of input words
//   min_sel_width()    smallest select width able to address n words
package mux_pkg;

  localparam int DEFAULT_WIDTH      = 8;
  localparam int DEFAULT_SEL_WIDTH  = 3;
  localparam int DEFAULT_NUM_INPUTS = 8;

  // Minimum select width for n inputs; a single-word mux still needs one bit.
  function automatic int min_sel_width(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage : mux_pkg

// File: rtl/mux_comb_select.sv
// mux_comb_select -- purely combinational N-to-1 word selector with range check.
//
// Ports:
//   sel       in   SEL_WIDTH          select index (unsigned)
//   data_in   in   NUM_INPUTS*WIDTH   flattened words, word i at [i*WIDTH +: WIDTH]
//   data_out  out  WIDTH              selected word, zero when sel is out of range
//   sel_err   out  1                  high when sel >= NUM_INPUTS
module mux_comb_select
  import mux_pkg::*;
#(
  parameter int WIDTH      = DEFAULT_WIDTH,
  parameter int SEL_WIDTH  = DEFAULT_SEL_WIDTH,
  parameter int NUM_INPUTS = DEFAULT_NUM_INPUTS
) (
  input  logic [SEL_WIDTH-1:0]        sel,
  input  logic [NUM_INPUTS*WIDTH-1:0] data_in,
  output logic [WIDTH-1:0]            data_out,
  output logic                        sel_err
);

  // One extra bit so NUM_INPUTS == 2**SEL_WIDTH is representable.
  localparam logic [SEL_WIDTH:0] NUM_INPUTS_EXT = (SEL_WIDTH + 1)'(NUM_INPUTS);

  logic [WIDTH-1:0] words [NUM_INPUTS];

  genvar gi;
  generate
    for (gi = 0; gi < NUM_INPUTS; gi++) begin : g_unpack
      assign words[gi] = data_in[gi*WIDTH +: WIDTH];
    end
  endgenerate

  // Compare-per-word rather than indexing the array with sel: an out-of-range
  // sel simply matches nothing, so data_out stays at its zero default and no
  // array access ever goes past the end.
  always_comb begin
    data_out = '0;
    sel_err  = ({1'b0, sel} >= NUM_INPUTS_EXT);
    for (int i = 0; i < NUM_INPUTS; i++) begin
      if (sel == SEL_WIDTH'(i)) begin
        data_out = words[i];
      end
    end
  end

endmodule : mux_comb_select

// File: rtl/data_multiplexer.sv
// data_multiplexer -- parameterised N-to-1 word multiplexer with a combinational
// path, a one-cycle registered path and select-range error reporting.
//
// Ports:
//   clk             in   1                  rising-edge clock
//   rst_n           in   1                  synchronous active-low reset
//   sel             in   SEL_WIDTH          select index
//   data_in         in   NUM_INPUTS*WIDTH   flattened input words
//   in_valid        in   1                  qualifies sel/data_in for the registered path
//   data_out        out  WIDTH              combinational selected word
//   sel_err         out  1                  combinational, sel >= NUM_INPUTS
//   data_out_q      out  WIDTH              registered selected word (holds when !in_valid)
//   out_valid       out  1                  registered copy of in_valid
//   sel_err_sticky  out  1                  latched on in_valid & sel_err, cleared by reset
module data_multiplexer
  import mux_pkg::*;
#(
  parameter int WIDTH      = DEFAULT_WIDTH,
  parameter int SEL_WIDTH  = DEFAULT_SEL_WIDTH,
  parameter int NUM_INPUTS = DEFAULT_NUM_INPUTS
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic [SEL_WIDTH-1:0]        sel,
  input  logic [NUM_INPUTS*WIDTH-1:0] data_in,
  input  logic                        in_valid,
  output logic [WIDTH-1:0]            data_out,
  output logic                        sel_err,
  output logic [WIDTH-1:0]            data_out_q,
  output logic                        out_valid,
  output logic                        sel_err_sticky
);

  // Reject unusable parameter sets at elaboration.
  generate
    if (NUM_INPUTS < 2) begin : g_bad_num_inputs
      $error("data_multiplexer: NUM_INPUTS must be >= 2");
    end
    if (SEL_WIDTH < min_sel_width(NUM_INPUTS)) begin : g_bad_sel_width
      $error("data_multiplexer: SEL_WIDTH too narrow to address NUM_INPUTS words");
    end
  endgenerate

  mux_comb_select #(
    .WIDTH      (WIDTH),
    .SEL_WIDTH  (SEL_WIDTH),
    .NUM_INPUTS (NUM_INPUTS)
  ) u_select (
    .sel      (sel),
    .data_in  (data_in),
    .data_out (data_out),
    .sel_err  (sel_err)
  );

  logic [WIDTH-1:0] data_out_d, data_out_q_q;
  logic             out_valid_d, out_valid_q;
  logic             sticky_d, sticky_q;

  always_comb begin
    data_out_d  = data_out_q_q;
    out_valid_d = in_valid;
    sticky_d    = sticky_q | (in_valid & sel_err);
    // The selector already zeroes out-of-range words, so capture it as-is.
    if (in_valid) begin
      data_out_d = data_out;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      data_out_q_q <= '0;
      out_valid_q  <= 1'b0;
      sticky_q     <= 1'b0;
    end else begin
      data_out_q_q <= data_out_d;
      out_valid_q  <= out_valid_d;
      sticky_q     <= sticky_d;
    end
  end

  assign data_out_q     = data_out_q_q;
  assign out_valid      = out_valid_q;
  assign sel_err_sticky = sticky_q;

endmodule : data_multiplexer

// File: tb/tb_data_multiplexer.sv
// tb_data_multiplexer -- directed self-checking bench for data_multiplexer.
// Two instances: default parameters (8 words) and a 5-word instance with a
// 3-bit select so that out-of-range selects can be exercised.
module tb_data_multiplexer;

  logic clk;
  logic rst_n;

  // Default-parameter instance
  logic [2:0]  sel8;
  logic [63:0] data_in8;
  logic        in_valid8;
  logic [7:0]  data_out8, data_out_q8;
  logic        sel_err8, out_valid8, sticky8;

  // Five-input instance
  logic [2:0]  sel5;
  logic [39:0] data_in5;
  logic        in_valid5;
  logic [7:0]  data_out5, data_out_q5;
  logic        sel_err5, out_valid5, sticky5;

  int errors = 0;
  int checks = 0;

  data_multiplexer u_dut8 (
    .clk            (clk),
    .rst_n          (rst_n),
    .sel            (sel8),
    .data_in        (data_in8),
    .in_valid       (in_valid8),
    .data_out       (data_out8),
    .sel_err        (sel_err8),
    .data_out_q     (data_out_q8),
    .out_valid      (out_valid8),
    .sel_err_sticky (sticky8)
  );

  data_multiplexer #(
    .WIDTH      (8),
    .SEL_WIDTH  (3),
    .NUM_INPUTS (5)
  ) u_dut5 (
    .clk            (clk),
    .rst_n          (rst_n),
    .sel            (sel5),
    .data_in        (data_in5),
    .in_valid       (in_valid5),
    .data_out       (data_out5),
    .sel_err        (sel_err5),
    .data_out_q     (data_out_q5),
    .out_valid      (out_valid5),
    .sel_err_sticky (sticky5)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance past the next rising edge so registered outputs have settled.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    sel8 = '0; data_in8 = '0; in_valid8 = 1'b0;
    sel5 = '0; data_in5 = '0; in_valid5 = 1'b0;
    tick();
    tick();
    checks++;
    if ({data_out_q8, out_valid8, sticky8} !== 10'd0) begin
      errors++;
      $display("FAIL reset_dut8: got q=%h v=%b s=%b, want q=00 v=0 s=0", data_out_q8, out_valid8, sticky8);
    end
    checks++;
    if ({data_out_q5, out_valid5, sticky5} !== 10'd0) begin
      errors++;
      $display("FAIL reset_dut5: got q=%h v=%b s=%b, want q=00 v=0 s=0", data_out_q5, out_valid5, sticky5);
    end
    @(negedge clk);
    rst_n = 1'b1;
    $display("reset: done");
  endtask

  task automatic test_sweep();
    for (int i = 0; i < 8; i++) data_in8[i*8 +: 8] = 8'(i);
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      sel8 = 3'(i);
      in_valid8 = 1'b1;
      #1;
      checks++;
      if (data_out8 !== 8'(i) || sel_err8 !== 1'b0) begin
        errors++;
        $display("FAIL sweep_comb sel=%0d: got out=%h err=%b, want out=%h err=0", i, data_out8, sel_err8, 8'(i));
      end
      tick();
      checks++;
      if (data_out_q8 !== 8'(i) || out_valid8 !== 1'b1) begin
        errors++;
        $display("FAIL sweep_reg sel=%0d: got q=%h v=%b, want q=%h v=1", i, data_out_q8, out_valid8, 8'(i));
      end
      $display("sweep: sel=%0d out=%h q=%h", i, data_out8, data_out_q8);
    end
  endtask

  task automatic test_word_update();
    @(negedge clk);
    data_in8[0 +: 8] = 8'hAA;
    sel8 = 3'd0;
    in_valid8 = 1'b1;
    #1;
    checks++;
    if (data_out8 !== 8'hAA) begin
      errors++;
      $display("FAIL update_w0_comb: got %h, want aa", data_out8);
    end
    tick();
    checks++;
    if (data_out_q8 !== 8'hAA || out_valid8 !== 1'b1) begin
      errors++;
      $display("FAIL update_w0_reg: got q=%h v=%b, want q=aa v=1", data_out_q8, out_valid8);
    end
    @(negedge clk);
    data_in8[32 +: 8] = 8'h55;
    sel8 = 3'd4;
    #1;
    checks++;
    if (data_out8 !== 8'h55) begin
      errors++;
      $display("FAIL update_w4_comb: got %h, want 55", data_out8);
    end
    tick();
    checks++;
    if (data_out_q8 !== 8'h55) begin
      errors++;
      $display("FAIL update_w4_reg: got q=%h, want 55", data_out_q8);
    end
    $display("word_update: w0=aa w4=55 q=%h", data_out_q8);
  endtask

  task automatic test_out_of_range();
    for (int i = 0; i < 5; i++) data_in5[i*8 +: 8] = 8'h10 + 8'(i);
    // Top legal index: no error.
    @(negedge clk);
    sel5 = 3'd4;
    in_valid5 = 1'b1;
    #1;
    checks++;
    if (data_out5 !== 8'h14 || sel_err5 !== 1'b0) begin
      errors++;
      $display("FAIL oor_sel4_comb: got out=%h err=%b, want out=14 err=0", data_out5, sel_err5);
    end
    tick();
    checks++;
    if (data_out_q5 !== 8'h14 || sticky5 !== 1'b0) begin
      errors++;
      $display("FAIL oor_sel4_reg: got q=%h sticky=%b, want q=14 sticky=0", data_out_q5, sticky5);
    end
    // First illegal index, without in_valid: flag but no sticky.
    @(negedge clk);
    sel5 = 3'd5;
    in_valid5 = 1'b0;
    #1;
    checks++;
    if (data_out5 !== 8'h00 || sel_err5 !== 1'b1) begin
      errors++;
      $display("FAIL oor_sel5_comb: got out=%h err=%b, want out=00 err=1", data_out5, sel_err5);
    end
    tick();
    checks++;
    if (sticky5 !== 1'b0 || data_out_q5 !== 8'h14) begin
      errors++;
      $display("FAIL oor_sel5_noval: got sticky=%b q=%h, want sticky=0 q=14", sticky5, data_out_q5);
    end
    @(negedge clk);
    sel5 = 3'd6;
    in_valid5 = 1'b1;
    #1;
    checks++;
    if (data_out5 !== 8'h00 || sel_err5 !== 1'b1) begin
      errors++;
      $display("FAIL oor_sel6_comb: got out=%h err=%b, want out=00 err=1", data_out5, sel_err5);
    end
    tick();
    checks++;
    if (data_out_q5 !== 8'h00 || sticky5 !== 1'b1 || out_valid5 !== 1'b1) begin
      errors++;
      $display("FAIL oor_sel6_reg: got q=%h sticky=%b v=%b, want q=00 sticky=1 v=1", data_out_q5, sticky5, out_valid5);
    end
    @(negedge clk);
    sel5 = 3'd2;
    #1;
    checks++;
    if (data_out5 !== 8'h12 || sel_err5 !== 1'b0) begin
      errors++;
      $display("FAIL oor_back_comb: got out=%h err=%b, want out=12 err=0", data_out5, sel_err5);
    end
    tick();
    checks++;
    if (sticky5 !== 1'b1 || data_out_q5 !== 8'h12) begin
      errors++;
      $display("FAIL oor_sticky_hold: got sticky=%b q=%h, want sticky=1 q=12", sticky5, data_out_q5);
    end
    $display("out_of_range: sticky=%b", sticky5);
  endtask

  task automatic test_hold();
    @(negedge clk);
    for (int i = 0; i < 8; i++) data_in8[i*8 +: 8] = 8'h30 + 8'(i);
    sel8 = 3'd1;
    in_valid8 = 1'b1;
    tick();
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      in_valid8 = 1'b0;
      sel8 = 3'(c + 5);
      data_in8[(c+5)*8 +: 8] = 8'hC0 + 8'(c);
      #1;
      checks++;
      if (data_out8 !== 8'hC0 + 8'(c)) begin
        errors++;
        $display("FAIL hold_comb cyc=%0d: got %h, want %h", c, data_out8, 8'hC0 + 8'(c));
      end
      tick();
      checks++;
      if (data_out_q8 !== 8'h31 || out_valid8 !== 1'b0) begin
        errors++;
        $display("FAIL hold_reg cyc=%0d: got q=%h v=%b, want q=31 v=0", c, data_out_q8, out_valid8);
      end
      $display("hold: cyc=%0d out=%h q=%h", c, data_out8, data_out_q8);
    end
  endtask

  task automatic test_reset_midstream();
    @(negedge clk);
    sel8 = 3'd3; in_valid8 = 1'b1;
    sel5 = 3'd3; in_valid5 = 1'b1;
    rst_n = 1'b0;
    tick();
    checks++;
    if ({data_out_q8, out_valid8, sticky8} !== 10'd0) begin
      errors++;
      $display("FAIL midreset_dut8: got q=%h v=%b s=%b, want q=00 v=0 s=0", data_out_q8, out_valid8, sticky8);
    end
    checks++;
    if ({data_out_q5, out_valid5, sticky5} !== 10'd0) begin
      errors++;
      $display("FAIL midreset_dut5: got q=%h v=%b s=%b, want q=00 v=0 s=0", data_out_q5, out_valid5, sticky5);
    end
    @(negedge clk);
    rst_n = 1'b1;
    in_valid8 = 1'b0;
    in_valid5 = 1'b0;
    $display("reset_midstream: done");
  endtask

  task automatic test_random();
    logic [7:0] exp8, exp5, exp_q8, exp_q5;
    logic       exp_v8, exp_v5, exp_s5, exp_err5;
    int         bad;
    exp_q8 = 8'h00; exp_q5 = 8'h00;
    exp_v8 = 1'b0;  exp_v5 = 1'b0;  exp_s5 = 1'b0;
    bad = 0;
    for (int c = 0; c < 1000; c++) begin
      @(negedge clk);
      data_in8  = {$urandom, $urandom};
      data_in5  = {8'($urandom), $urandom};
      sel8      = 3'($urandom_range(0, 7));
      sel5      = 3'($urandom_range(0, 7));
      in_valid8 = 1'($urandom);
      in_valid5 = 1'($urandom);
      exp8      = data_in8[sel8*8 +: 8];
      exp_err5  = (sel5 > 3'd4);
      exp5      = exp_err5 ? 8'h00 : data_in5[sel5*8 +: 8];
      #1;
      checks++;
      if (data_out8 !== exp8 || sel_err8 !== 1'b0 || data_out5 !== exp5 || sel_err5 !== exp_err5) begin
        errors++; bad++;
        $display("FAIL rand_comb cyc=%0d: got o8=%h e8=%b o5=%h e5=%b, want o8=%h e8=0 o5=%h e5=%b",
                 c, data_out8, sel_err8, data_out5, sel_err5, exp8, exp5, exp_err5);
      end
      if (in_valid8) exp_q8 = exp8;
      if (in_valid5) exp_q5 = exp5;
      exp_v8 = in_valid8;
      exp_v5 = in_valid5;
      exp_s5 = exp_s5 | (in_valid5 & exp_err5);
      tick();
      checks++;
      if (data_out_q8 !== exp_q8 || out_valid8 !== exp_v8 || sticky8 !== 1'b0 ||
          data_out_q5 !== exp_q5 || out_valid5 !== exp_v5 || sticky5 !== exp_s5) begin
        errors++; bad++;
        $display("FAIL rand_reg cyc=%0d: got q8=%h v8=%b s8=%b q5=%h v5=%b s5=%b, want q8=%h v8=%b s8=0 q5=%h v5=%b s5=%b",
                 c, data_out_q8, out_valid8, sticky8, data_out_q5, out_valid5, sticky5,
                 exp_q8, exp_v8, exp_q5, exp_v5, exp_s5);
      end
      if (c % 100 == 99) $display("random: %0d cycles, %0d bad", c + 1, bad);
    end
  endtask

  initial begin
    test_reset();
    test_sweep();
    test_word_update();
    test_out_of_range();
    test_hold();
    test_reset_midstream();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule : tb_data_multiplexer

// File: doc/data_multiplexer.md
Name: data_multiplexer

Overview:
- Parameterised N-to-1 word multiplexer for datapath steering.
- Combinational path: `data_out` equals `data_in[sel]` in the same cycle.
- Registered path: a one-cycle-latency copy of the selected word, with a valid flag.
- Select-range checking: out-of-range `sel` raises an immediate flag and a sticky error flag.

Parameters:
- WIDTH, 8, bits per data word.
- SEL_WIDTH, 3, select bus width. Must satisfy 2**SEL_WIDTH >= NUM_INPUTS; violation is an elaboration-time error.
- NUM_INPUTS, 8, number of input words. Must be >= 2.

Ports:
- clk  in  1  rising-edge clock.
- rst_n  in  1  synchronous active-low reset.
- sel  in  SEL_WIDTH  input select index.
- data_in  in  NUM_INPUTS*WIDTH  flattened inputs; word i is data_in[i*WIDTH +: WIDTH].
- in_valid  in  1  qualifies sel/data_in for the registered path.
- data_out  out  WIDTH  combinational selected word.
- sel_err  out  1  combinational; high when sel >= NUM_INPUTS.
- data_out_q  out  WIDTH  registered selected word.
- out_valid  out  1  registered copy of in_valid.
- sel_err_sticky  out  1  set on any in_valid cycle with sel_err; cleared only by reset.

Behaviour:
- Combinational path, no latency:
  - sel < NUM_INPUTS: data_out = word[sel] and sel_err = 0.
  - sel >= NUM_INPUTS: data_out = 0 and sel_err = 1.
  - Any change on sel or data_in propagates within the same delta. Reset does not affect this path.
- Reset: on a rising clk with rst_n = 0, data_out_q = 0, out_valid = 0, sel_err_sticky = 0. Reset wins over in_valid in the same cycle. Reset mid-stream drops the pending word.
- Registered path, 1-cycle latency. On a rising clk with rst_n = 1:
  - out_valid <= in_valid.
  - If in_valid: data_out_q <= data_out, which is 0 for out-of-range sel.
  - If !in_valid: data_out_q holds its previous value.
  - Back-to-back in_valid cycles give one output per cycle. There is no backpressure.
- sel_err_sticky is set on a rising clk when in_valid & sel_err, and stays set until reset.
- Selection rules:
  - Unsigned compare on sel.
  - No X-propagation masking is required.
  - Output width always equals WIDTH; no truncation or extension of data.
- With default parameters, every sel value is legal, so sel_err is constantly 0.

Decomposition:
- Shared package mux_pkg holds:
  - default WIDTH, SEL_WIDTH, NUM_INPUTS constants;
  - a function computing the minimum SEL_WIDTH from NUM_INPUTS (clog2), used by the parameter check.
- One sub-module is natural: mux_comb_select, the purely combinational selector plus range check, producing data_out and sel_err.
- Top level data_multiplexer adds the output register, out_valid and sticky error logic.

Test Plan:
- Default parameters, data_in[i] = i, sweep sel 0..7 at one value per cycle.
  - data_out == i in the same cycle.
  - With in_valid = 1: data_out_q == i and out_valid = 1 one cycle later.
  - sel_err stays 0 throughout.
- Word updates:
  - Set data_in[0] = 8'hAA, sel = 0 -> data_out == 8'hAA immediately.
  - Set data_in[4] = 8'h55, sel = 4 -> data_out == 8'h55.
  - With in_valid, data_out_q follows one cycle later.
- Out of range with NUM_INPUTS = 5, SEL_WIDTH = 3, sel = 6, in_valid = 1:
  - data_out == 0 and sel_err = 1 in the same cycle.
  - Next cycle: data_out_q == 0 and sel_err_sticky = 1.
  - sel_err_sticky stays 1 after sel returns to 2.
- Hold: in_valid = 0 for 3 cycles while sel and data change -> data_out_q unchanged and out_valid = 0; data_out still tracks combinationally.
- Reset mid-stream: rst_n = 0 on a cycle with in_valid = 1, sel = 3 -> next cycle data_out_q == 0, out_valid = 0, sel_err_sticky = 0.
- Random: 1000 cycles of random sel/data/in_valid against a scoreboard.
  - data_out == data_in[sel] on every cycle.
  - data_out_q == the previous cycle's selection whenever out_valid = 1.
